imm_decode_stage: RTL

IMM_DECODE_STAGE -- requirements
Module: imm_decode_stage

---
 rtl/riscv_pkg.sv | 39 +++
 rtl/imm_extract.sv | 64 ++++++
 rtl/imm_decode_stage.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V opcode constants, immediate format codes and skid-buffer states.
// Consumed by imm_extract and imm_decode_stage.
package riscv_pkg;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;

   localparam logic [2:0] F3_SLLI = 3'b001;
   localparam logic [2:0] F3_SRXI = 3'b101;

   typedef enum logic [2:0] {
      FMT_NONE = 3'd0,
      FMT_I    = 3'd1,
      FMT_S    = 3'd2,
      FMT_B    = 3'd3,
      FMT_U    = 3'd4,
      FMT_J    = 3'd5
   } imm_fmt_e;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } skid_state_e;

   // Immediate shifts carry a zero-extended shamt instead of a signed immediate.
   function automatic logic is_shift_imm(input logic [31:0] instr);
      return (instr[6:0] == OPC_OP_IMM) &&
             ((instr[14:12] == F3_SLLI) || (instr[14:12] == F3_SRXI));
   endfunction

endpackage

// File: rtl/imm_extract.sv
// Combinational format classification and immediate extraction for one
// 32-bit RISC-V instruction, sign-extended to XLEN (32 or 64).
module imm_extract
   import riscv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:0]     instr,
   output imm_fmt_e        fmt,
   output logic [XLEN-1:0] imm
);

   imm_fmt_e    fmt_s;
   logic [31:0] raw_s;

   // Opcode to immediate format
   always_comb begin
      fmt_s = FMT_NONE;
      case (instr[6:0])
         OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_SYSTEM: fmt_s = FMT_I;
         OPC_STORE:                                  fmt_s = FMT_S;
         OPC_BRANCH:                                 fmt_s = FMT_B;
         OPC_LUI, OPC_AUIPC:                         fmt_s = FMT_U;
         OPC_JAL:                                    fmt_s = FMT_J;
         default:                                    fmt_s = FMT_NONE;
      endcase
   end

   // 32-bit immediate, already sign-correct in bit 31 for the widening below
   always_comb begin
      raw_s = 32'd0;
      case (fmt_s)
         FMT_I: begin
            if (is_shift_imm(instr)) begin
               if (XLEN == 64) begin
                  raw_s = {26'd0, instr[25:20]};
               end else begin
                  raw_s = {27'd0, instr[24:20]};
               end
            end else begin
               raw_s = {{20{instr[31]}}, instr[31:20]};
            end
         end
         FMT_S:   raw_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         FMT_B:   raw_s = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                           instr[11:8], 1'b0};
         FMT_U:   raw_s = {instr[31:12], 12'd0};
         FMT_J:   raw_s = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                           instr[30:21], 1'b0};
         default: raw_s = 32'd0;
      endcase
   end

   assign fmt = fmt_s;

   generate
      if (XLEN == 64) begin : g_xlen64
         assign imm = {{32{raw_s[31]}}, raw_s};
      end else begin : g_xlen32
         assign imm = raw_s;
      end
   endgenerate

endmodule

// File: rtl/imm_decode_stage.sv
// Immediate decode pipeline stage: imm_extract feeding a 2-entry skid buffer
// with registered outputs. Define IMM_DECODE_ILLEGAL_EN to add out_illegal.
module imm_decode_stage
   import riscv_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int TAG_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_instr,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_imm,
   output logic [2:0]       out_fmt,
   output logic [TAG_W-1:0] out_tag
`ifdef IMM_DECODE_ILLEGAL_EN
   ,
   output logic             out_illegal
`endif
);

   imm_fmt_e        ext_fmt_s;
   logic [XLEN-1:0] ext_imm_s;
   logic [2:0]      dec_fmt_s;
   logic [XLEN-1:0] dec_imm_s;

   skid_state_e      state_r;
   skid_state_e      state_nxt_s;
   logic             in_ready_r;
   logic             out_valid_r;
   logic [XLEN-1:0]  head_imm_r;
   logic [2:0]       head_fmt_r;
   logic [TAG_W-1:0] head_tag_r;
   logic [XLEN-1:0]  skid_imm_r;
   logic [2:0]       skid_fmt_r;
   logic [TAG_W-1:0] skid_tag_r;

   logic accept_s;
   logic drain_s;
   logic load_head_in_s;
   logic load_head_skid_s;
   logic load_skid_s;

   imm_extract #(
      .XLEN (XLEN)
   ) u_extract (
      .instr (in_instr),
      .fmt   (ext_fmt_s),
      .imm   (ext_imm_s)
   );

`ifdef IMM_DECODE_ILLEGAL_EN
   logic dec_ill_s;
   logic head_ill_r;
   logic skid_ill_r;

   // Unknown opcodes and compressed-length encodings are flagged and zeroed
   always_comb begin
      dec_ill_s = (ext_fmt_s == FMT_NONE) || (in_instr[1:0] != 2'b11);
      if (dec_ill_s) begin
         dec_fmt_s = FMT_NONE;
         dec_imm_s = '0;
      end else begin
         dec_fmt_s = ext_fmt_s;
         dec_imm_s = ext_imm_s;
      end
   end
`else
   // Decoded payload passes straight through; NONE already carries a zero imm
   always_comb begin
      dec_fmt_s = ext_fmt_s;
      dec_imm_s = ext_imm_s;
   end
`endif

   assign accept_s = in_valid && in_ready_r;
   assign drain_s  = out_valid_r && out_ready;

   // Skid-buffer next state and datapath load selects
   always_comb begin
      state_nxt_s      = state_r;
      load_head_in_s   = 1'b0;
      load_head_skid_s = 1'b0;
      load_skid_s      = 1'b0;
      case (state_r)
         ST_EMPTY: begin
            if (accept_s) begin
               state_nxt_s    = ST_ONE;
               load_head_in_s = 1'b1;
            end else begin
               state_nxt_s = ST_EMPTY;
            end
         end
         ST_ONE: begin
            if (accept_s && drain_s) begin
               state_nxt_s    = ST_ONE;
               load_head_in_s = 1'b1;
            end else if (accept_s) begin
               state_nxt_s = ST_TWO;
               load_skid_s = 1'b1;
            end else if (drain_s) begin
               state_nxt_s = ST_EMPTY;
            end else begin
               state_nxt_s = ST_ONE;
            end
         end
         ST_TWO: begin
            if (drain_s) begin
               state_nxt_s      = ST_ONE;
               load_head_skid_s = 1'b1;
            end else begin
               state_nxt_s = ST_TWO;
            end
         end
         default: state_nxt_s = ST_EMPTY;
      endcase
   end

   // State, handshake flags and payload registers; in_ready looks only at next state
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r     <= ST_EMPTY;
         in_ready_r  <= 1'b0;
         out_valid_r <= 1'b0;
         head_imm_r  <= '0;
         head_fmt_r  <= 3'd0;
         head_tag_r  <= '0;
         skid_imm_r  <= '0;
         skid_fmt_r  <= 3'd0;
         skid_tag_r  <= '0;
      end else begin
         state_r     <= state_nxt_s;
         in_ready_r  <= (state_nxt_s != ST_TWO);
         out_valid_r <= (state_nxt_s != ST_EMPTY);
         if (load_head_in_s) begin
            head_imm_r <= dec_imm_s;
            head_fmt_r <= dec_fmt_s;
            head_tag_r <= in_tag;
         end else if (load_head_skid_s) begin
            head_imm_r <= skid_imm_r;
            head_fmt_r <= skid_fmt_r;
            head_tag_r <= skid_tag_r;
         end
         if (load_skid_s) begin
            skid_imm_r <= dec_imm_s;
            skid_fmt_r <= dec_fmt_s;
            skid_tag_r <= in_tag;
         end
      end
   end

`ifdef IMM_DECODE_ILLEGAL_EN
   // Illegal flag travels with its entry through the same two slots
   always_ff @(posedge clk) begin
      if (reset) begin
         head_ill_r <= 1'b0;
         skid_ill_r <= 1'b0;
      end else begin
         if (load_head_in_s) begin
            head_ill_r <= dec_ill_s;
         end else if (load_head_skid_s) begin
            head_ill_r <= skid_ill_r;
         end
         if (load_skid_s) begin
            skid_ill_r <= dec_ill_s;
         end
      end
   end

   assign out_illegal = head_ill_r;
`endif

   assign in_ready  = in_ready_r;
   assign out_valid = out_valid_r;
   assign out_imm   = head_imm_r;
   assign out_fmt   = head_fmt_r;
   assign out_tag   = head_tag_r;

endmodule
